// File: rtl/mem_pkg.sv
// Shared definitions for the data-RAM arbiter: access codes, response owner
// encoding, the legal range of the fetch starvation limit and the muxed
// request record handed to the RAM.
package mem_pkg;

  // RAM access codes (bit 2 = zero-extend, bits 1:0 = size)
  localparam logic [2:0] ACC_LB  = 3'b000;
  localparam logic [2:0] ACC_LH  = 3'b001;
  localparam logic [2:0] ACC_LW  = 3'b010;
  localparam logic [2:0] ACC_LBU = 3'b100;
  localparam logic [2:0] ACC_LHU = 3'b101;

  // Legal range of consecutive fetch denials before fetch is forced through
  localparam int STARVE_MIN = 1;
  localparam int STARVE_MAX = 15;

  // Which port owns the response slot in the following cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // The single request that reaches the RAM in a cycle
  typedef struct packed {
    logic        we;
    logic [2:0]  access;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Keep an out-of-range starvation limit inside what the 4-bit counter holds
  function automatic logic [3:0] clamp_limit(input int lim);
    if (lim < STARVE_MIN) return 4'(STARVE_MIN);
    if (lim > STARVE_MAX) return 4'(STARVE_MAX);
    return 4'(lim);
  endfunction

endpackage

// File: rtl/access_check.sv
// Legality and alignment check for one RAM request. Purely combinational;
// the two flags are mutually exclusive (an illegal code never also reports
// misalignment).
module access_check (
  input  logic [1:0] addr_lo,
  input  logic [2:0] access,
  input  logic       we,
  output logic       illegal,
  output logic       misaligned
);
  import mem_pkg::*;

  // Classify the access code and test the low address bits against its size
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (access)
      ACC_LB, ACC_LBU: misaligned = 1'b0;
      ACC_LH, ACC_LHU: misaligned = addr_lo[0];
      ACC_LW:          misaligned = |addr_lo;
      default:         illegal    = 1'b1;
    endcase
    // Zero-extending codes only make sense for loads
    if (we && access[2]) begin
      illegal = 1'b1;
    end
    if (illegal) begin
      misaligned = 1'b0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single-port data RAM between instruction fetch and the
// load/store unit. Grants are combinational; every grant produces exactly one
// response on the owning port in the following cycle. Requests that fail the
// access check are granted but never reach the RAM and answer with err=1.
module ram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  // load/store port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_access,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // RAM side
  output logic        ram_load,
  output logic        ram_store,
  output logic [2:0]  ram_access,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);
  import mem_pkg::*;

  localparam logic [3:0] LIMIT = clamp_limit(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  owner_e     owner_q, owner_d;
  logic       err_q, err_d;
  logic       store_q, store_d;

  logic       fetch_win, data_win, any_win;
  mem_req_t   sel;
  logic       illegal, misaligned, chk_err;
  logic       issue;
  logic       load_ok;

  // Data normally wins a collision; fetch wins once it has waited LIMIT cycles
  always_comb begin
    fetch_win = if_req && (!d_req || (starve_q == LIMIT));
    data_win  = d_req && !fetch_win;
    any_win   = fetch_win || data_win;
  end

  assign if_gnt = fetch_win;
  assign d_gnt  = data_win;

  // Route the winner onto the shared request; idle cycles leave the bus at 0
  always_comb begin
    sel = '0;
    if (fetch_win) begin
      sel.we     = 1'b0;
      sel.access = ACC_LW;
      sel.addr   = if_addr;
    end else if (data_win) begin
      sel.we     = d_we;
      sel.access = d_access;
      sel.addr   = d_addr;
      sel.wdata  = d_wdata;
    end
  end

  access_check u_check (
    .addr_lo    (sel.addr[1:0]),
    .access     (sel.access),
    .we         (sel.we),
    .illegal    (illegal),
    .misaligned (misaligned)
  );

  assign chk_err = illegal || misaligned;

  // Only a legal grant outside reset may touch memory
  always_comb begin
    issue      = any_win && !chk_err && !rst;
    ram_load   = issue && !sel.we;
    ram_store  = issue && sel.we;
    ram_access = sel.access;
    ram_addr   = sel.addr;
    ram_wdata  = sel.wdata;
  end

  // Count consecutive denied fetch cycles, saturating at the limit
  always_comb begin
    if (!if_req || fetch_win) begin
      starve_d = 4'd0;
    end else if (starve_q < LIMIT) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Capture who owns next cycle's response and how it must be answered
  always_comb begin
    if (fetch_win) begin
      owner_d = OWN_IF;
    end else if (data_win) begin
      owner_d = OWN_D;
    end else begin
      owner_d = OWN_NONE;
    end
    err_d   = any_win && chk_err;
    store_d = sel.we;
  end

  // State register; a grant in the reset cycle is dropped here
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
      store_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
      store_q  <= store_d;
    end
  end

  // Read data is forwarded only for loads that actually reached the RAM
  assign load_ok = !err_q && !store_q;

  // Drive the response onto the owning port only
  always_comb begin
    if_rvalid = 1'b0;
    if_err    = 1'b0;
    if_rdata  = 32'h0;
    d_rvalid  = 1'b0;
    d_err     = 1'b0;
    d_rdata   = 32'h0;
    case (owner_q)
      OWN_IF: begin
        if_rvalid = 1'b1;
        if_err    = err_q;
        if_rdata  = load_ok ? ram_rdata : 32'h0;
      end
      OWN_D: begin
        d_rvalid = 1'b1;
        d_err    = err_q;
        d_rdata  = load_ok ? ram_rdata : 32'h0;
      end
      default: begin
        if_rvalid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a driver applies one request set per
// cycle, predicts grants and responses from a byte-level memory model and
// queues them; a monitor on the falling edge pops and compares.
module tb_ram_arbiter;
  import mem_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_access = 3'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        ram_load, ram_store;
  logic [2:0]  ram_access;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_access(d_access), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .ram_load(ram_load), .ram_store(ram_store), .ram_access(ram_access),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Two independent byte memories: one behind the RAM pins, one for prediction
  logic [7:0] ram_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  function automatic int acc_size(input logic [2:0] acc);
    case (acc)
      ACC_LB, ACC_LBU: return 1;
      ACC_LH, ACC_LHU: return 2;
      default:         return 4;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input bit use_ram, input logic [31:0] a);
    if (use_ram) return ram_mem.exists(a) ? ram_mem[a] : 8'h00;
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Little-endian read with sign or zero extension to 32 bits
  function automatic logic [31:0] mem_read(input bit use_ram, input logic [31:0] a, input logic [2:0] acc);
    int sz = acc_size(acc);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < sz; i++) begin
      v = v | (32'(get_byte(use_ram, a + 32'(i))) << (8 * i));
    end
    if (!acc[2] && sz < 4 && v[8 * sz - 1]) begin
      v = v | ~((32'd1 << (8 * sz)) - 32'd1);
    end
    return v;
  endfunction

  function automatic void mem_write(input bit use_ram, input logic [31:0] a, input logic [2:0] acc, input logic [31:0] wd);
    int sz = acc_size(acc);
    for (int i = 0; i < sz; i++) begin
      if (use_ram) ram_mem[a + 32'(i)] = wd[8 * i +: 8];
      else         ref_mem[a + 32'(i)] = wd[8 * i +: 8];
    end
  endfunction

  // Rejected when the code is unknown, a store is zero-extending, or the
  // address is not a multiple of the access size
  function automatic bit ref_err(input bit we, input logic [2:0] acc, input logic [31:0] a);
    bit legal;
    legal = (acc inside {ACC_LB, ACC_LH, ACC_LW, ACC_LBU, ACC_LHU}) && !(we && acc[2]);
    if (!legal) return 1'b1;
    return (a % 32'(acc_size(acc))) != 32'd0;
  endfunction

  // RAM behind the arbiter: writes at the edge, registered read, garbage otherwise
  always @(posedge clk) begin
    if (ram_store) mem_write(1'b1, ram_addr, ram_access, ram_wdata);
    if (ram_load) ram_rdata <= mem_read(1'b1, ram_addr, ram_access);
    else          ram_rdata <= $urandom;
  end

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t if_q[$];
  rsp_t d_q[$];
  int   ref_denied = 0;

  // One cycle of stimulus plus prediction; ig/dg report the expected grants
  task automatic drive(input bit r, input bit ir, input logic [31:0] ia,
                       input bit dr, input bit we, input logic [2:0] acc,
                       input logic [31:0] da, input logic [31:0] wd,
                       output bit ig, output bit dg);
    bit f_win, d_win, e, wwe;
    logic [2:0] wacc;
    logic [31:0] wa;
    rsp_t rs;
    @(posedge clk);
    #1;
    rst = r; if_req = ir; if_addr = ia;
    d_req = dr; d_we = we; d_access = acc; d_addr = da; d_wdata = wd;
    #3;
    f_win = ir && (!dr || ref_denied >= LIMIT);
    d_win = dr && !f_win;
    ig = f_win;
    dg = d_win;
    if (r) begin
      ref_denied = 0;
      chk("rst_ram_load", 32'(ram_load), 32'd0);
      chk("rst_ram_store", 32'(ram_store), 32'd0);
      ig = 1'b0;
      dg = 1'b0;
      return;
    end
    chk("if_gnt", 32'(if_gnt), 32'(f_win));
    chk("d_gnt", 32'(d_gnt), 32'(d_win));
    chk("excl_gnt", 32'(if_gnt & d_gnt), 32'd0);
    if (!ir || f_win) ref_denied = 0;
    else if (ref_denied < LIMIT) ref_denied++;
    if (!f_win && !d_win) begin
      chk("idle_ram_load", 32'(ram_load), 32'd0);
      chk("idle_ram_store", 32'(ram_store), 32'd0);
      return;
    end
    wwe  = d_win ? we : 1'b0;
    wacc = d_win ? acc : ACC_LW;
    wa   = d_win ? da : ia;
    e    = ref_err(wwe, wacc, wa);
    chk("ram_load", 32'(ram_load), 32'(!e && !wwe));
    chk("ram_store", 32'(ram_store), 32'(!e && wwe));
    if (!e && wwe) mem_write(1'b0, wa, wacc, wd);
    rs.due  = cyc + 1;
    rs.err  = e;
    rs.data = (e || wwe) ? 32'h0 : mem_read(1'b0, wa, wacc);
    if (f_win) if_q.push_back(rs);
    else       d_q.push_back(rs);
  endtask

  task automatic compare_rsp(input string port, input logic v, input logic e,
                             input logic [31:0] dat, input bit have, input rsp_t h,
                             output bit pop);
    pop = 1'b0;
    if (have && h.due == cyc) begin
      pop = 1'b1;
      chk({port, "_rvalid"}, 32'(v), 32'd1);
      if (v) begin
        chk({port, "_err"}, 32'(e), 32'(h.err));
        chk({port, "_rdata"}, dat, h.data);
        $display("rsp %s cycle %0d rdata=%h err=%0d", port, cyc, dat, e);
      end
    end else begin
      chk({port, "_rvalid_idle"}, 32'(v), 32'd0);
    end
  endtask

  // Monitor: every falling edge, match each port against its queue head
  always @(negedge clk) begin
    rsp_t h;
    bit   pop;
    chk("excl_rvalid", 32'(if_rvalid & d_rvalid), 32'd0);
    h = '{due: -1, data: 32'h0, err: 1'b0};
    if (if_q.size() > 0) h = if_q[0];
    compare_rsp("if", if_rvalid, if_err, if_rdata, if_q.size() > 0, h, pop);
    if (pop) void'(if_q.pop_front());
    h = '{due: -1, data: 32'h0, err: 1'b0};
    if (d_q.size() > 0) h = d_q[0];
    compare_rsp("d", d_rvalid, d_err, d_rdata, d_q.size() > 0, h, pop);
    if (pop) void'(d_q.pop_front());
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ig, dg;
    bit pi, pd, pwe, rr;
    logic [31:0] pia, pda, pwd;
    logic [2:0] pacc;
    logic [2:0] codes [5];
    codes = '{ACC_LB, ACC_LH, ACC_LW, ACC_LBU, ACC_LHU};
    pi = 1'b0; pd = 1'b0; pwe = 1'b0; rr = 1'b0;
    pia = 32'h0; pda = 32'h0; pwd = 32'h0; pacc = 3'b0;

    // Reset
    drive(1, 0, 0, 0, 0, 3'b0, 0, 0, ig, dg);
    drive(1, 0, 0, 0, 0, 3'b0, 0, 0, ig, dg);
    drive(0, 0, 0, 0, 0, 3'b0, 0, 0, ig, dg);
    chk("reset_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("reset_d_err", 32'(d_err), 32'd0);

    // Store ack, then store + lone fetch of the stored word
    drive(0, 0, 0, 1, 1, ACC_LW, 32'h10, 32'h1234_5678, ig, dg);
    drive(0, 0, 0, 1, 1, ACC_LW, 32'h100, 32'hDEAD_BEEF, ig, dg);
    drive(0, 1, 32'h100, 0, 0, 3'b0, 0, 0, ig, dg);

    // Misaligned half and illegal code
    drive(0, 0, 0, 1, 0, ACC_LH, 32'h101, 0, ig, dg);
    drive(0, 0, 0, 1, 0, 3'b011, 32'h100, 0, ig, dg);

    // Byte store then signed and unsigned byte loads back-to-back
    drive(0, 0, 0, 1, 1, ACC_LB, 32'h200, 32'h0000_0080, ig, dg);
    drive(0, 0, 0, 1, 0, ACC_LB, 32'h200, 0, ig, dg);
    drive(0, 0, 0, 1, 0, ACC_LBU, 32'h200, 0, ig, dg);

    // Both held for 10 cycles: fetch gets every fifth slot
    for (int i = 0; i < 10; i++) begin
      drive(0, 1, 32'h100, 1, 0, ACC_LW, 32'h10, 0, ig, dg);
      chk("starve_slot", 32'(if_gnt), 32'((i % 5) == 4));
    end
    drive(0, 0, 0, 0, 0, 3'b0, 0, 0, ig, dg);

    // Build up starvation, reset during a granted load, then re-check pattern
    drive(0, 1, 32'h100, 1, 0, ACC_LW, 32'h200, 0, ig, dg);
    drive(0, 1, 32'h100, 1, 0, ACC_LW, 32'h200, 0, ig, dg);
    drive(1, 1, 32'h100, 1, 0, ACC_LW, 32'h200, 0, ig, dg);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 32'h100, 1, 0, ACC_LW, 32'h200, 0, ig, dg);
      chk("post_rst_slot", 32'(if_gnt), 32'(i == 4));
    end
    drive(0, 0, 0, 0, 0, 3'b0, 0, 0, ig, dg);

    // Randomized traffic; a requester holds its request until granted
    for (int i = 0; i < 1500; i++) begin
      if (!pi && $urandom_range(0, 2) != 0) begin
        pi  = 1'b1;
        pia = 32'h200 + 32'($urandom_range(0, 15)) * 32'd4;
        if ($urandom_range(0, 7) == 0) pia = pia + 32'($urandom_range(1, 3));
      end
      if (!pd && $urandom_range(0, 2) != 0) begin
        pd   = 1'b1;
        pwe  = 1'($urandom_range(0, 1));
        pacc = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                           : codes[$urandom_range(0, 4)];
        pda  = 32'h200 + 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) pda = pda & ~32'h3;
        pwd  = $urandom;
      end
      rr = ($urandom_range(0, 199) == 0);
      drive(rr, pi, pia, pd, pwe, pacc, pda, pwd, ig, dg);
      if (ig) pi = 1'b0;
      if (dg) pd = 1'b0;
    end

    // Drain and confirm every predicted response was seen
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 3'b0, 0, 0, ig, dg);
    chk("if_queue_drained", 32'(if_q.size()), 32'd0);
    chk("d_queue_drained", 32'(d_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares the single-port byte-addressable data RAM between the instruction-fetch port and the load/store port of the core. Grants one requester per cycle, drives the RAM strobes, and routes the one-cycle-latency read data back to the owner. Rejects misaligned or illegal accesses with an error response instead of touching memory. Sits between the core's fetch/LSU stages and the RAM instance.

## Interface
- STARVE_LIMIT, 4: consecutive cycles fetch may be denied before it is forced to win (1..15)
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request (word read)
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  fetch response valid
- if_rdata  out  32  fetch data, meaningful only when if_rvalid
- if_err  out  1  fetch misaligned, qualified by if_rvalid
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_access  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- d_addr  in  32  data byte address
- d_wdata  in  32  store data (low bytes used per size)
- d_gnt  out  1  data accepted this cycle (combinational)
- d_rvalid  out  1  data response valid (load data or store ack)
- d_rdata  out  32  load data, 0 for stores/errors
- d_err  out  1  data misaligned/illegal, qualified by d_rvalid
- ram_load, ram_store  out  1 each  RAM strobes
- ram_access  out  3  RAM access code
- ram_addr  out  32  RAM byte address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM registered read data (valid cycle after ram_load)

## Operation
- Arbitration each cycle: only one req → that one granted. Both → data wins, unless starve_cnt == STARVE_LIMIT, then fetch wins.
- starve_cnt (4 bits): +1 when if_req && !if_gnt, saturating at STARVE_LIMIT; cleared when if_gnt or !if_req.
- Granted fetch: ram_load=1, ram_access=010, ram_addr=if_addr.
- Granted data: ram_load=!d_we, ram_store=d_we, ram_access=d_access, ram_addr=d_addr, ram_wdata=d_wdata.
- Access check (per granted request): illegal codes 011/110/111; store with access[2]=1 illegal; half with addr[0]≠0, word with addr[1:0]≠0 misaligned. Fetch is always word-checked.
- Failed check: request still granted, both RAM strobes 0, response next cycle with err=1, rdata=0.
- Response register: owner (NONE/IF/D), err, is_store captured at grant. Next cycle: owner's rvalid=1; rdata = ram_rdata for legal loads, else 0.
- No request granted → strobes 0, ram_* buses hold 0.
- rst: strobes forced 0 in the same cycle; owner=NONE, starve_cnt=0, err=0. Any grant in the reset cycle is discarded and produces no response.

## Timing
- Grant: combinational, same cycle as req; requester must hold req/addr/data stable until gnt.
- Latency: exactly 1 cycle grant→rvalid for loads, stores and errors; back-to-back grants give back-to-back responses, full throughput.
- Store takes effect at the grant edge; a load at the same address granted the next cycle returns the new data.
- Reset values: all rvalid/err 0, rdata 0, gnt 0, strobes 0.
- gnt is never asserted to both ports in one cycle; rvalid is never asserted to both ports in one cycle.

## Structure
- Shared package mem_pkg: access-code constants (LB, LH, LW, LBU, LHU), owner encoding, STARVE_LIMIT bound.
- One sub-module: access_check (addr[1:0], access, we → illegal, misaligned), instantiated once on the muxed granted request.
- Top holds arbiter logic, starve counter, response register.

## Test plan
- Lone fetch at 0x100 after store LW 0xDEADBEEF at 0x100 → if_gnt same cycle, if_rvalid next cycle, if_rdata 0xDEADBEEF.
- Both reqs held for 10 cycles, STARVE_LIMIT=4 → data granted 4 cycles, fetch on cycle 5, pattern repeats; never both gnt.
- d_access=001 at 0x101 load → d_gnt, no ram_load, next cycle d_rvalid=1, d_err=1, d_rdata=0; same for access=011 at 0x100.
- SB 0x80 at 0x200 then LB / LBU at 0x200 back-to-back → d_rdata 0xFFFFFF80 then 0x00000080, consecutive cycles.
- rst asserted in cycle a load is granted → no rvalid following, starve_cnt 0, strobes 0 during reset.
- Store ack: SW at 0x10 → d_rvalid next cycle, d_err=0, d_rdata=0.
